cpu6502_lite: RTL and testbench

Parametrised multicycle 8-bit CPU core executing a 6502-compatible instruction subset. It sits between program/data memory (asynchronous read, synchronous write) and the debug/display logic.
- Adds to the previous core:
  - N/V/Z/C flags
  - zero-page load/store
  - register transfers and increments
  - absolute jump and conditional branches
  - configurable reset vector and address width
  - optional illegal-opcode trap

---
 rtl/cpu6502_lite.sv | 229 ++++++++++++++++++++++
 tb/tb_cpu6502_lite.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6502_lite.sv
// cpu6502_lite: multicycle 8-bit core running a 6502 subset (flags, zero page, JMP, BNE/BEQ).
// Define CPU_ILLEGAL_TRAP_EN to halt on undefined opcodes; otherwise they execute as NOPs.
module cpu6502_lite #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        dout,
    output logic              we,
    output logic              sync,
    output logic              halted,
    output logic [7:0]        a_out,
    output logic [7:0]        x_out,
    output logic [7:0]        y_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [7:0]        opcode_out,
    output logic [3:0]        flags_out
);

    localparam int unsigned ZP_PAD_W = ADDR_W - 8;

    localparam logic [7:0] OP_TAX    = 8'hAA;
    localparam logic [7:0] OP_TXA    = 8'h8A;
    localparam logic [7:0] OP_INX    = 8'hE8;
    localparam logic [7:0] OP_DEX    = 8'hCA;
    localparam logic [7:0] OP_INY    = 8'hC8;
    localparam logic [7:0] OP_DEY    = 8'h88;
    localparam logic [7:0] OP_SEC    = 8'h38;
    localparam logic [7:0] OP_CLC    = 8'h18;
    localparam logic [7:0] OP_NOP    = 8'hEA;
    localparam logic [7:0] OP_LDA_I  = 8'hA9;
    localparam logic [7:0] OP_LDX_I  = 8'hA2;
    localparam logic [7:0] OP_LDY_I  = 8'hA0;
    localparam logic [7:0] OP_AND_I  = 8'h29;
    localparam logic [7:0] OP_ORA_I  = 8'h09;
    localparam logic [7:0] OP_EOR_I  = 8'h49;
    localparam logic [7:0] OP_ADC_I  = 8'h69;
    localparam logic [7:0] OP_SBC_I  = 8'hE9;
    localparam logic [7:0] OP_LDA_ZP = 8'hA5;
    localparam logic [7:0] OP_STA_ZP = 8'h85;
    localparam logic [7:0] OP_JMP    = 8'h4C;
    localparam logic [7:0] OP_BNE    = 8'hD0;
    localparam logic [7:0] OP_BEQ    = 8'hF0;

`ifdef CPU_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {S_FETCH, S_EXEC0, S_EXEC1, S_HALT} state_t;

    function automatic logic is_legal(input logic [7:0] op);
        case (op)
            OP_TAX, OP_TXA, OP_INX, OP_DEX, OP_INY, OP_DEY, OP_SEC, OP_CLC, OP_NOP,
            OP_LDA_I, OP_LDX_I, OP_LDY_I, OP_AND_I, OP_ORA_I, OP_EOR_I, OP_ADC_I,
            OP_SBC_I, OP_LDA_ZP, OP_STA_ZP, OP_JMP, OP_BNE, OP_BEQ: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction
`else
    typedef enum logic [1:0] {S_FETCH, S_EXEC0, S_EXEC1} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [7:0]        r_a, r_x, r_y, r_opcode, r_lo;
    logic [7:0]        w_a_nxt, w_x_nxt, w_y_nxt, w_op_nxt, w_lo_nxt;
    logic              r_n, r_v, r_z, r_c;
    logic              w_n_nxt, w_v_nxt, w_z_nxt, w_c_nxt;

    logic [ADDR_W-1:0] w_pc_inc, w_rel, w_br_tgt, w_zp_addr;
    logic [15:0]       w_jmp;
    logic [7:0]        w_alu_m, w_res;
    logic [8:0]        w_sum;
    logic              w_ovf, w_set_nz, w_is_zp, w_needs_ex1;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_rel       = {{ZP_PAD_W{din[7]}}, din};
    assign w_br_tgt    = w_pc_inc + w_rel;
    assign w_zp_addr   = {{ZP_PAD_W{1'b0}}, r_lo};
    assign w_jmp       = {din, r_lo};
    // SBC is ADC of the inverted operand; C=1 then means no borrow
    assign w_alu_m     = (r_opcode == OP_SBC_I) ? ~din : din;
    assign w_sum       = {1'b0, r_a} + {1'b0, w_alu_m} + {8'd0, r_c};
    assign w_ovf       = (r_a[7] == w_alu_m[7]) && (w_sum[7] != r_a[7]);
    assign w_is_zp     = (r_opcode == OP_LDA_ZP) || (r_opcode == OP_STA_ZP);
    assign w_needs_ex1 = w_is_zp || (r_opcode == OP_JMP);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                w_state_nxt = S_EXEC0;
`ifdef CPU_ILLEGAL_TRAP_EN
                if (!is_legal(din)) w_state_nxt = S_HALT;
`endif
            end
            S_EXEC0: w_state_nxt = w_needs_ex1 ? S_EXEC1 : S_FETCH;
            S_EXEC1: w_state_nxt = S_FETCH;
            default: w_state_nxt = r_state;
        endcase
    end

    // Bus outputs; the write strobe is masked by reset so an aborted STA never writes
    always_comb begin
        addr = r_pc;
        sync = 1'b0;
        we   = 1'b0;
        dout = r_a;
        case (r_state)
            S_FETCH: sync = 1'b1;
            S_EXEC1: begin
                if (w_is_zp) addr = w_zp_addr;
                if ((r_opcode == OP_STA_ZP) && !reset) we = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_a_nxt  = r_a;
        w_x_nxt  = r_x;
        w_y_nxt  = r_y;
        w_n_nxt  = r_n;
        w_v_nxt  = r_v;
        w_z_nxt  = r_z;
        w_c_nxt  = r_c;
        w_pc_nxt = r_pc;
        w_op_nxt = r_opcode;
        w_lo_nxt = r_lo;
        w_res    = 8'h00;
        w_set_nz = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_op_nxt = din;
                w_pc_nxt = w_pc_inc;
            end
            S_EXEC0: begin
                case (r_opcode)
                    OP_TAX:   begin w_x_nxt = r_a;          w_res = w_x_nxt; w_set_nz = 1'b1; end
                    OP_TXA:   begin w_a_nxt = r_x;          w_res = w_a_nxt; w_set_nz = 1'b1; end
                    OP_INX:   begin w_x_nxt = r_x + 8'd1;   w_res = w_x_nxt; w_set_nz = 1'b1; end
                    OP_DEX:   begin w_x_nxt = r_x - 8'd1;   w_res = w_x_nxt; w_set_nz = 1'b1; end
                    OP_INY:   begin w_y_nxt = r_y + 8'd1;   w_res = w_y_nxt; w_set_nz = 1'b1; end
                    OP_DEY:   begin w_y_nxt = r_y - 8'd1;   w_res = w_y_nxt; w_set_nz = 1'b1; end
                    OP_SEC:   w_c_nxt = 1'b1;
                    OP_CLC:   w_c_nxt = 1'b0;
                    OP_LDA_I: begin w_a_nxt = din;          w_res = din;     w_set_nz = 1'b1; w_pc_nxt = w_pc_inc; end
                    OP_LDX_I: begin w_x_nxt = din;          w_res = din;     w_set_nz = 1'b1; w_pc_nxt = w_pc_inc; end
                    OP_LDY_I: begin w_y_nxt = din;          w_res = din;     w_set_nz = 1'b1; w_pc_nxt = w_pc_inc; end
                    OP_AND_I: begin w_a_nxt = r_a & din;    w_res = w_a_nxt; w_set_nz = 1'b1; w_pc_nxt = w_pc_inc; end
                    OP_ORA_I: begin w_a_nxt = r_a | din;    w_res = w_a_nxt; w_set_nz = 1'b1; w_pc_nxt = w_pc_inc; end
                    OP_EOR_I: begin w_a_nxt = r_a ^ din;    w_res = w_a_nxt; w_set_nz = 1'b1; w_pc_nxt = w_pc_inc; end
                    OP_ADC_I, OP_SBC_I: begin
                        w_a_nxt  = w_sum[7:0];
                        w_c_nxt  = w_sum[8];
                        w_v_nxt  = w_ovf;
                        w_res    = w_sum[7:0];
                        w_set_nz = 1'b1;
                        w_pc_nxt = w_pc_inc;
                    end
                    OP_LDA_ZP, OP_STA_ZP, OP_JMP: begin
                        w_lo_nxt = din;
                        w_pc_nxt = w_pc_inc;
                    end
                    OP_BNE:   w_pc_nxt = r_z ? w_pc_inc : w_br_tgt;
                    OP_BEQ:   w_pc_nxt = r_z ? w_br_tgt : w_pc_inc;
                    default:  ;
                endcase
            end
            S_EXEC1: begin
                case (r_opcode)
                    OP_LDA_ZP: begin w_a_nxt = din; w_res = din; w_set_nz = 1'b1; end
                    OP_JMP:    w_pc_nxt = w_jmp[ADDR_W-1:0];
                    default:   ;
                endcase
            end
            default: ;
        endcase
        if (w_set_nz) begin
            w_n_nxt = w_res[7];
            w_z_nxt = (w_res == 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= 8'h00;
            r_x      <= 8'h00;
            r_y      <= 8'h00;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_pc     <= RESET_PC[ADDR_W-1:0];
            r_opcode <= OP_NOP;
            r_lo     <= 8'h00;
        end else begin
            r_a      <= w_a_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_n      <= w_n_nxt;
            r_v      <= w_v_nxt;
            r_z      <= w_z_nxt;
            r_c      <= w_c_nxt;
            r_pc     <= w_pc_nxt;
            r_opcode <= w_op_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    assign a_out      = r_a;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign pc_out     = r_pc;
    assign opcode_out = r_opcode;
    assign flags_out  = {r_n, r_v, r_z, r_c};

endmodule

// File: tb/tb_cpu6502_lite.sv
// Scoreboard bench for cpu6502_lite: expected fetches/writes are queued, a monitor checks them.
module tb_cpu6502_lite;

    typedef struct packed {
        logic [15:0] cyc;
        logic [15:0] pc;
        logic [7:0]  a;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  f;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_tot = 0;
    int          n_bad = 0;
    exp_t        fq[$];
    wr_t         wq[$];
    logic [7:0]  prog[$];
    logic [7:0]  mem   [0:65535];
    logic [7:0]  mem12 [0:4095];

    logic [7:0]  din, dout, a_out, x_out, y_out, opcode_out;
    logic [15:0] addr, pc_out;
    logic        we, sync, halted;
    logic [3:0]  flags_out;

    logic [7:0]  din12, dout12, a12, x12, y12, op12;
    logic [11:0] addr12, pc12;
    logic        we12, sync12, halted12;
    logic [3:0]  flags12;

    cpu6502_lite #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .din(din), .addr(addr), .dout(dout), .we(we),
        .sync(sync), .halted(halted), .a_out(a_out), .x_out(x_out), .y_out(y_out),
        .pc_out(pc_out), .opcode_out(opcode_out), .flags_out(flags_out)
    );

    cpu6502_lite #(.ADDR_W(12), .RESET_PC(16'h0100)) dut12 (
        .clk(clk), .reset(reset), .din(din12), .addr(addr12), .dout(dout12), .we(we12),
        .sync(sync12), .halted(halted12), .a_out(a12), .x_out(x12), .y_out(y12),
        .pc_out(pc12), .opcode_out(op12), .flags_out(flags12)
    );

    assign din   = mem[addr];
    assign din12 = mem12[addr12];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = reset ? 1 : cyc + 1;
        if (we)   mem[addr]     = dout;
        if (we12) mem12[addr12] = dout12;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every opcode fetch and every write strobe is matched against the queues
    initial forever begin
        @(negedge clk);
        if (mon_en && !reset) begin
            if (sync) begin
                if (fq.size() == 0) begin
                    n_tot++; n_bad++;
                    $display("FAIL fetch_extra: got fetch at %h cycle %0d expected none", addr, cyc);
                end else begin
                    exp_t e;
                    e = fq.pop_front();
                    check("fetch_pc", {16'(cyc), addr, pc_out}, {e.cyc, e.pc, e.pc});
                    check("fetch_regs", {a_out, x_out, y_out, flags_out}, {e.a, e.x, e.y, e.f});
                end
            end
            if (we) begin
                if (wq.size() == 0) begin
                    n_tot++; n_bad++;
                    $display("FAIL write_extra: got write %h to %h expected none", dout, addr);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("write", {addr, dout}, {w.a, w.d});
                end
            end
        end
    end

    task automatic ef(input int c, input logic [15:0] pc, input logic [7:0] a, input logic [7:0] x,
                      input logic [7:0] y, input logic [3:0] f);
        exp_t e;
        e.cyc = 16'(c); e.pc = pc; e.a = a; e.x = x; e.y = y; e.f = f;
        fq.push_back(e);
    endtask

    task automatic ew(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wq.push_back(w);
    endtask

    task automatic begin_prog();
        @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    endtask

    task automatic load(input int base);
        foreach (prog[i]) mem[16'(base + i)] = prog[i];
    endtask

    task automatic end_reset(input logic mon);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = mon;
        @(negedge clk);
        check("reset_state", {opcode_out, we, halted, sync}, {8'hEA, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while (fq.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        mon_en = 1'b0;
        n_tot++;
        if (fq.size() != 0 || wq.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got fetches left %0d writes left %0d expected 0", name, fq.size(), wq.size());
        end
        fq.delete();
        wq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem12[i] = 8'hEA;
        mem12[12'h100] = 8'h4C; mem12[12'h101] = 8'h34; mem12[12'h102] = 8'h12;
        mem12[12'h234] = 8'hA9; mem12[12'h235] = 8'h77;

        // LDA #$50; ADC #$50
        begin_prog();
        prog = '{8'hA9, 8'h50, 8'h69, 8'h50};
        load(0);
        ef(1, 16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3, 16'h0002, 8'h50, 8'h00, 8'h00, 4'b0000);
        ef(5, 16'h0004, 8'hA0, 8'h00, 8'h00, 4'b1100);
        end_reset(1'b1);
        drain("adc", 40);

        // SEC; LDA #5; SBC #6; CLC; LDX #$FF; INX
        begin_prog();
        prog = '{8'h38, 8'hA9, 8'h05, 8'hE9, 8'h06, 8'h18, 8'hA2, 8'hFF, 8'hE8};
        load(0);
        ef(1,  16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3,  16'h0001, 8'h00, 8'h00, 8'h00, 4'b0001);
        ef(5,  16'h0003, 8'h05, 8'h00, 8'h00, 4'b0001);
        ef(7,  16'h0005, 8'hFF, 8'h00, 8'h00, 4'b1000);
        ef(9,  16'h0006, 8'hFF, 8'h00, 8'h00, 4'b1000);
        ef(11, 16'h0008, 8'hFF, 8'hFF, 8'h00, 4'b1000);
        ef(13, 16'h0009, 8'hFF, 8'h00, 8'h00, 4'b0010);
        end_reset(1'b1);
        drain("sbc", 60);

        // LDA #$3C; STA $10; LDA #0; LDA $10
        begin_prog();
        prog = '{8'hA9, 8'h3C, 8'h85, 8'h10, 8'hA9, 8'h00, 8'hA5, 8'h10};
        load(0);
        ef(1,  16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3,  16'h0002, 8'h3C, 8'h00, 8'h00, 4'b0000);
        ef(6,  16'h0004, 8'h3C, 8'h00, 8'h00, 4'b0000);
        ef(8,  16'h0006, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(11, 16'h0008, 8'h3C, 8'h00, 8'h00, 4'b0000);
        ew(16'h0010, 8'h3C);
        end_reset(1'b1);
        drain("zp", 60);

        // LDA #0; BEQ +4 at $0002
        begin_prog();
        prog = '{8'hA9, 8'h00, 8'hF0, 8'h04};
        load(0);
        ef(1, 16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3, 16'h0002, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(5, 16'h0008, 8'h00, 8'h00, 8'h00, 4'b0010);
        end_reset(1'b1);
        drain("beq", 40);

        // BNE -2 with Z=1 falls through; BNE -10 with Z=0 goes back to $0000
        begin_prog();
        prog = '{8'hA9, 8'h00, 8'hEA, 8'hEA, 8'hD0, 8'hFE, 8'hA9, 8'h01, 8'hD0, 8'hF6};
        load(0);
        ef(1,  16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3,  16'h0002, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(5,  16'h0003, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(7,  16'h0004, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(9,  16'h0006, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(11, 16'h0008, 8'h01, 8'h00, 8'h00, 4'b0000);
        ef(13, 16'h0000, 8'h01, 8'h00, 8'h00, 4'b0000);
        end_reset(1'b1);
        drain("bne", 60);

        // JMP $FFFE, then BNE +2 whose PC wraps through $0000
        begin_prog();
        prog = '{8'hA9, 8'h01, 8'h4C, 8'hFE, 8'hFF};
        load(0);
        mem[16'hFFFE] = 8'hD0;
        mem[16'hFFFF] = 8'h02;
        ef(1, 16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3, 16'h0002, 8'h01, 8'h00, 8'h00, 4'b0000);
        ef(6, 16'hFFFE, 8'h01, 8'h00, 8'h00, 4'b0000);
        ef(8, 16'h0002, 8'h01, 8'h00, 8'h00, 4'b0000);
        end_reset(1'b1);
        drain("jmp_wrap", 40);

        // Transfers, increments and logic ops
        begin_prog();
        prog = '{8'hA0, 8'h00, 8'h88, 8'hC8, 8'hA9, 8'h80, 8'hAA, 8'hCA,
                 8'h8A, 8'h29, 8'h0F, 8'h09, 8'hF0, 8'h49, 8'hFF};
        load(0);
        ef(1,  16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(3,  16'h0002, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(5,  16'h0003, 8'h00, 8'h00, 8'hFF, 4'b1000);
        ef(7,  16'h0004, 8'h00, 8'h00, 8'h00, 4'b0010);
        ef(9,  16'h0006, 8'h80, 8'h00, 8'h00, 4'b1000);
        ef(11, 16'h0007, 8'h80, 8'h80, 8'h00, 4'b1000);
        ef(13, 16'h0008, 8'h80, 8'h7F, 8'h00, 4'b0000);
        ef(15, 16'h0009, 8'h7F, 8'h7F, 8'h00, 4'b0000);
        ef(17, 16'h000B, 8'h0F, 8'h7F, 8'h00, 4'b0000);
        ef(19, 16'h000D, 8'hFF, 8'h7F, 8'h00, 4'b1000);
        ef(21, 16'h000F, 8'h00, 8'h7F, 8'h00, 4'b0010);
        end_reset(1'b1);
        drain("xfer", 80);

        // Reset during EXEC1 of STA must suppress the write
        begin_prog();
        prog = '{8'hA9, 8'h3C, 8'h85, 8'h10};
        load(0);
        mem[16'h0010] = 8'hAA;
        end_reset(1'b0);
        repeat (4) @(posedge clk);
        #1 check("sta_before_abort", {we, addr, dout}, {1'b1, 16'h0010, 8'h3C});
        reset = 1'b1;
        #1 check("sta_abort_we", {31'd0, we}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_state", {addr, pc_out, a_out, x_out, y_out, flags_out, sync},
              {16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1});
        check("abort_mem", {56'd0, mem[16'h0010]}, {56'd0, 8'hAA});

        // Opcode $02, then SEC; LDA #$FF; ADC #0 (carry out, zero result)
        begin_prog();
        prog = '{8'h02, 8'h38, 8'hA9, 8'hFF, 8'h69, 8'h00};
        load(0);
        ef(1, 16'h0000, 8'h00, 8'h00, 8'h00, 4'b0000);
`ifdef CPU_ILLEGAL_TRAP_EN
        end_reset(1'b1);
        drain("trap", 20);
        repeat (3) @(negedge clk);
        check("trap_state", {halted, sync, we, addr, pc_out, opcode_out},
              {1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 8'h02});
`else
        ef(3, 16'h0001, 8'h00, 8'h00, 8'h00, 4'b0000);
        ef(5, 16'h0002, 8'h00, 8'h00, 8'h00, 4'b0001);
        ef(7, 16'h0004, 8'hFF, 8'h00, 8'h00, 4'b1001);
        ef(9, 16'h0006, 8'h00, 8'h00, 8'h00, 4'b0011);
        end_reset(1'b1);
        drain("illegal_nop", 40);
        check("illegal_halted", {63'd0, halted}, 64'd0);
`endif

        // 12-bit core, reset vector $100: JMP $1234 lands at $234
        begin_prog();
        end_reset(1'b0);
        check("a12_reset", {sync12, addr12, pc12, a12}, {1'b1, 12'h100, 12'h100, 8'h00});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a12_jmp", {sync12, addr12, pc12}, {1'b1, 12'h234, 12'h234});
        repeat (2) @(negedge clk);
        check("a12_lda", {sync12, pc12, a12, flags12}, {1'b1, 12'h236, 8'h77, 4'b0000});

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
